// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one byte-wide synchronous RAM port between instruction fetch (IF,
//   read-only, always 4 bytes) and the MEM stage (1/2/4-byte loads and
//   stores). Each access is split into byte cycles. Read data is assembled
//   little-endian and returned zero-extended.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 kills an in-flight IF fetch (READ or DONE only)
//   if_req/if_addr        fetch request (held until if_done or flush)
//   if_data/if_done       fetched word, one-cycle completion pulse
//   mem_req/mem_we        load/store request, 1 = store
//   mem_width/mem_addr    00 byte, 01 half, 1x word; byte address
//   mem_wdata             store data (low bytes used)
//   mem_rdata/mem_done    zero-extended load data, one-cycle completion pulse
//   ram_addr/ram_dout     RAM byte address and write byte
//   ram_din               RAM read byte, valid the cycle after its address
//   ram_wr                RAM write enable
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_width,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              ram_wr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Control (asynchronously reset)
  logic        r_gnt_mem;    // side owning the current transaction, 1 = MEM
  logic        r_last_mem;   // last_grant, 1 = MEM
  logic [2:0]  r_cnt;        // byte counter i
  logic [2:0]  r_n;          // byte count n (1, 2 or 4)
  logic [31:0] r_if_data;
  logic [31:0] r_mem_rdata;

  // Datapath (no reset needed, always loaded on acceptance)
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;

  logic        w_accept;
  logic        w_pick_mem;
  logic [2:0]  w_req_n;
  logic        w_kill;
  logic        w_rd_last;
  logic        w_wr_last;
  logic [31:0] w_byte_addr;
  logic [7:0]  w_wbyte;
  logic [31:0] w_buf_nxt;

  // Arbitration: a lone requester wins; on a tie the side that was not
  // granted last wins. last_grant resets to IF, so MEM takes the first tie.
  assign w_accept   = if_req | mem_req;
  assign w_pick_mem = mem_req & (~if_req | ~r_last_mem);

  always_comb begin
    w_req_n = 3'd4;
    if (w_pick_mem) begin
      case (mem_width)
        2'b00:   w_req_n = 3'd1;
        2'b01:   w_req_n = 3'd2;
        default: w_req_n = 3'd4;
      endcase
    end
  end

  // Flush only ever kills IF transactions.
  assign w_kill      = flush & ~r_gnt_mem;
  assign w_rd_last   = (r_cnt == r_n);
  assign w_wr_last   = (r_cnt == (r_n - 3'd1));
  assign w_byte_addr = r_base + {29'd0, r_cnt};

  always_comb begin
    w_wbyte = r_wdata[7:0];
    case (r_cnt[1:0])
      2'd0: w_wbyte = r_wdata[7:0];
      2'd1: w_wbyte = r_wdata[15:8];
      2'd2: w_wbyte = r_wdata[23:16];
      2'd3: w_wbyte = r_wdata[31:24];
      default: w_wbyte = r_wdata[7:0];
    endcase
  end

  // In READ cycle i>=1 the RAM returns the byte addressed in cycle i-1.
  always_comb begin
    w_buf_nxt = r_buf;
    case (r_cnt)
      3'd1: w_buf_nxt[7:0]   = ram_din;
      3'd2: w_buf_nxt[15:8]  = ram_din;
      3'd3: w_buf_nxt[23:16] = ram_din;
      3'd4: w_buf_nxt[31:24] = ram_din;
      default: w_buf_nxt = r_buf;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_pick_mem && mem_we) ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        if (w_kill) begin
          w_state_nxt = S_IDLE;
        end else if (w_rd_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_WRITE: begin
        if (w_wr_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    ram_wr   = 1'b0;
    ram_addr = '0;
    ram_dout = 8'd0;
    if_done  = 1'b0;
    mem_done = 1'b0;
    case (r_state)
      S_READ: begin
        if (r_cnt < r_n) begin
          ram_addr = w_byte_addr[ADDR_W-1:0];
        end
      end
      S_WRITE: begin
        ram_wr   = 1'b1;
        ram_addr = w_byte_addr[ADDR_W-1:0];
        ram_dout = w_wbyte;
      end
      S_DONE: begin
        // A late flush still suppresses the IF completion pulse.
        if_done  = ~r_gnt_mem & ~flush;
        mem_done = r_gnt_mem;
      end
      default: begin
        ram_wr = 1'b0;
      end
    endcase
  end

  assign if_data   = r_if_data;
  assign mem_rdata = r_mem_rdata;

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt_mem   <= 1'b0;
      r_last_mem  <= 1'b0;
      r_cnt       <= 3'd0;
      r_n         <= 3'd4;
      r_if_data   <= 32'd0;
      r_mem_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_gnt_mem  <= w_pick_mem;
            r_last_mem <= w_pick_mem;
            r_cnt      <= 3'd0;
            r_n        <= w_req_n;
          end
        end
        S_READ: begin
          r_cnt <= r_cnt + 3'd1;
          // Publish the word one edge early so it is valid during DONE.
          if (w_rd_last && !w_kill) begin
            if (r_gnt_mem) begin
              r_mem_rdata <= w_buf_nxt;
            end else begin
              r_if_data <= w_buf_nxt;
            end
          end
        end
        S_WRITE: begin
          r_cnt <= r_cnt + 3'd1;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_accept) begin
      r_base  <= w_pick_mem ? mem_addr : if_addr;
      r_wdata <= mem_wdata;
      r_buf   <= 32'd0;  // unused upper lanes read as zero
    end else if (r_state == S_READ) begin
      r_buf <= w_buf_nxt;
    end
  end

endmodule
